datapath_ctrl: RTL and testbench

- Multi-cycle Moore controller that sequences the shared register-file / shifter / ALU datapath for one 16-bit instruction at a time.
- Latches an instruction on a start handshake, decodes it, then drives register-file read/write selects, A/B/C/status load enables, operand selects, shift code and ALU opcode over a fixed cycle sequence.
- Returns to idle and reasserts ready when the instruction completes.
- Sits between the instruction source (bench or future fetch unit) and the datapath.

---
 rtl/datapath_ctrl.sv | 153 +++++++++++++++
 tb/tb_datapath_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
// Multi-cycle Moore controller sequencing the register-file / shifter / ALU datapath
// for one 16-bit instruction at a time; all control outputs are registered with the state.
module datapath_ctrl #(
   parameter int unsigned IW   = 16,
   parameter int unsigned RSEL = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s,
   input  logic [IW-1:0]   instr,
   output logic            w,
   output logic            done,
   output logic            err,
   output logic [RSEL-1:0] readnum,
   output logic [RSEL-1:0] writenum,
   output logic            write,
   output logic            loada,
   output logic            loadb,
   output logic            loadc,
   output logic            loads,
   output logic            asel,
   output logic            bsel,
   output logic [1:0]      shift,
   output logic [1:0]      ALUop,
   output logic [1:0]      vsel,
   output logic [15:0]     sximm8
);

   typedef enum logic [2:0] {
      ST_WAIT, ST_DECODE, ST_LOAD_A, ST_LOAD_B, ST_EXEC, ST_WRITE_C, ST_WRITE_IMM
   } state_t;

   localparam logic [4:0] C_MOVI = 5'b110_10;
   localparam logic [4:0] C_MOVR = 5'b110_00;
   localparam logic [4:0] C_ADD  = 5'b101_00;
   localparam logic [4:0] C_CMP  = 5'b101_01;
   localparam logic [4:0] C_AND  = 5'b101_10;
   localparam logic [4:0] C_MVN  = 5'b101_11;

   state_t      state;
   logic [IW-1:0] ir;

   logic [4:0] code;
   logic [2:0] rn, rd, rm;
   logic [1:0] sh;
   logic       is_movi, is_movr, is_add, is_cmp, is_and, is_mvn;

   function automatic logic legal(input logic [4:0] c);
      return (c == C_MOVI) || (c == C_MOVR) || (c == C_ADD) ||
             (c == C_CMP)  || (c == C_AND)  || (c == C_MVN);
   endfunction

   // Field decode of the latched instruction
   assign code    = ir[15:11];
   assign rn      = ir[10:8];
   assign rd      = ir[7:5];
   assign sh      = ir[4:3];
   assign rm      = ir[2:0];
   assign is_movi = (code == C_MOVI);
   assign is_movr = (code == C_MOVR);
   assign is_add  = (code == C_ADD);
   assign is_cmp  = (code == C_CMP);
   assign is_and  = (code == C_AND);
   assign is_mvn  = (code == C_MVN);

   assign sximm8  = {{8{ir[7]}}, ir[7:0]};
   assign bsel    = 1'b0;

   // Outputs are loaded with the values belonging to the state being entered
   always_ff @(posedge clk) begin
      w        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      readnum  <= '0;
      writenum <= '0;
      shift    <= 2'b00;
      ALUop    <= 2'b00;
      vsel     <= 2'b00;
      if (!rst_n) begin
         state <= ST_WAIT;
         ir    <= '0;
         w     <= 1'b1;
      end else begin
         case (state)
            ST_WAIT: begin
               if (s) begin
                  ir    <= instr;
                  state <= ST_DECODE;
                  err   <= !legal(instr[15:11]);
               end else begin
                  w <= 1'b1;
               end
            end
            ST_DECODE: begin
               if (is_movi) begin
                  state    <= ST_WRITE_IMM;
                  write    <= 1'b1;
                  writenum <= RSEL'(rn);
                  vsel     <= 2'b01;
                  done     <= 1'b1;
               end else if (is_add || is_cmp || is_and) begin
                  state   <= ST_LOAD_A;
                  readnum <= RSEL'(rn);
                  loada   <= 1'b1;
               end else if (is_movr || is_mvn) begin
                  state   <= ST_LOAD_B;
                  readnum <= RSEL'(rm);
                  loadb   <= 1'b1;
               end else begin
                  state <= ST_WAIT;
                  w     <= 1'b1;
               end
            end
            ST_LOAD_A: begin
               state   <= ST_LOAD_B;
               readnum <= RSEL'(rm);
               loadb   <= 1'b1;
            end
            ST_LOAD_B: begin
               state <= ST_EXEC;
               shift <= sh;
               asel  <= is_movr || is_mvn;
               ALUop <= is_cmp ? 2'b01 : is_and ? 2'b10 : is_mvn ? 2'b11 : 2'b00;
               loads <= is_cmp;
               loadc <= !is_cmp;
               done  <= is_cmp;
            end
            ST_EXEC: begin
               if (is_cmp) begin
                  state <= ST_WAIT;
                  w     <= 1'b1;
               end else begin
                  state    <= ST_WRITE_C;
                  write    <= 1'b1;
                  writenum <= RSEL'(rd);
                  done     <= 1'b1;
               end
            end
            default: begin
               state <= ST_WAIT;
               w     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: walks each instruction class cycle by cycle
// against hand-derived control values.
module tb_datapath_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s;
   logic [15:0] instr;
   logic        w, done, err, write, loada, loadb, loadc, loads, asel, bsel;
   logic [2:0]  readnum, writenum;
   logic [1:0]  shift, ALUop, vsel;
   logic [15:0] sximm8;

   int npass = 0;
   int ntotal = 0;

   datapath_ctrl dut (
      .clk(clk), .rst_n(rst_n), .s(s), .instr(instr),
      .w(w), .done(done), .err(err),
      .readnum(readnum), .writenum(writenum), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
      .vsel(vsel), .sximm8(sximm8)
   );

   always #5 clk = ~clk;

   // flag vector order: {w, done, err, write, loada, loadb, loadc, loads}
   localparam logic [7:0] F_IDLE  = 8'b1000_0000;
   localparam logic [7:0] F_NONE  = 8'b0000_0000;
   localparam logic [7:0] F_WDONE = 8'b0101_0000;
   localparam logic [7:0] F_LA    = 8'b0000_1000;
   localparam logic [7:0] F_LB    = 8'b0000_0100;
   localparam logic [7:0] F_LC    = 8'b0000_0010;
   localparam logic [7:0] F_CMPX  = 8'b0100_0001;
   localparam logic [7:0] F_ERR   = 8'b0010_0000;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_flags(input string tag, input logic [7:0] exp);
      chk(tag, 16'({w, done, err, write, loada, loadb, loadc, loads}), 16'(exp));
   endtask

   initial begin
      rst_n = 1'b0;
      s     = 1'b0;
      instr = 16'h0000;
      tick();
      tick();
      chk_flags("reset_flags", F_IDLE);
      chk("reset_bsel", 16'(bsel), 16'h0);
      rst_n = 1'b1;
      tick();
      chk_flags("idle_flags", F_IDLE);

      // MOVI R1,#-10
      s = 1'b1; instr = 16'hD1F6;
      tick(); chk_flags("movi_decode", F_NONE);
      s = 1'b0;
      tick(); chk_flags("movi_wimm", F_WDONE);
      chk("movi_writenum", 16'(writenum), 16'd1);
      chk("movi_vsel", 16'(vsel), 16'd1);
      chk("movi_sximm8", sximm8, 16'hFFF6);
      tick(); chk_flags("movi_wait", F_IDLE);

      // ADD R2,R2,R0,LSL#1 with s pulsed and instr changed mid-flight
      s = 1'b1; instr = 16'hA248;
      tick(); chk_flags("add_decode", F_NONE);
      s = 1'b1; instr = 16'hE000;
      tick(); chk_flags("add_loada", F_LA);
      chk("add_readnum_a", 16'(readnum), 16'd2);
      s = 1'b0;
      tick(); chk_flags("add_loadb", F_LB);
      chk("add_readnum_b", 16'(readnum), 16'd0);
      tick(); chk_flags("add_exec", F_LC);
      chk("add_aluop", 16'(ALUop), 16'd0);
      chk("add_shift", 16'(shift), 16'd1);
      chk("add_asel", 16'(asel), 16'd0);
      tick(); chk_flags("add_writec", F_WDONE);
      chk("add_writenum", 16'(writenum), 16'd2);
      chk("add_vsel", 16'(vsel), 16'd0);
      chk("add_ir_held", sximm8, 16'h0048);
      tick(); chk_flags("add_wait", F_IDLE);

      // CMP R3,R4
      s = 1'b1; instr = 16'hAB04;
      tick(); chk_flags("cmp_decode", F_NONE);
      s = 1'b0;
      tick(); chk_flags("cmp_loada", F_LA);
      chk("cmp_readnum_a", 16'(readnum), 16'd3);
      tick(); chk_flags("cmp_loadb", F_LB);
      chk("cmp_readnum_b", 16'(readnum), 16'd4);
      tick(); chk_flags("cmp_exec", F_CMPX);
      chk("cmp_aluop", 16'(ALUop), 16'd1);
      tick(); chk_flags("cmp_wait", F_IDLE);

      // MVN R5,R6
      s = 1'b1; instr = 16'hB8A6;
      tick(); chk_flags("mvn_decode", F_NONE);
      s = 1'b0;
      tick(); chk_flags("mvn_loadb", F_LB);
      chk("mvn_readnum", 16'(readnum), 16'd6);
      tick(); chk_flags("mvn_exec", F_LC);
      chk("mvn_asel", 16'(asel), 16'd1);
      chk("mvn_aluop", 16'(ALUop), 16'd3);
      tick(); chk_flags("mvn_writec", F_WDONE);
      chk("mvn_writenum", 16'(writenum), 16'd5);
      tick(); chk_flags("mvn_wait", F_IDLE);

      // Illegal encoding
      s = 1'b1; instr = 16'hE000;
      tick(); chk_flags("ill_decode", F_ERR);
      s = 1'b0;
      tick(); chk_flags("ill_wait", F_IDLE);

      // Back-to-back MOVI with s held high
      s = 1'b1; instr = 16'hD1F6;
      tick(); chk_flags("b2b_decode1", F_NONE);
      tick(); chk_flags("b2b_wimm1", F_WDONE);
      tick(); chk_flags("b2b_wait", F_IDLE);
      tick(); chk_flags("b2b_decode2", F_NONE);
      s = 1'b0;
      tick(); chk_flags("b2b_wimm2", F_WDONE);
      tick(); chk_flags("b2b_end", F_IDLE);

      // Reset during EXEC of ADD aborts the write
      s = 1'b1; instr = 16'hA248;
      tick(); chk_flags("rst_decode", F_NONE);
      s = 1'b0;
      tick(); chk_flags("rst_loada", F_LA);
      tick(); chk_flags("rst_loadb", F_LB);
      tick(); chk_flags("rst_exec", F_LC);
      rst_n = 1'b0;
      tick(); chk_flags("rst_abort", F_IDLE);
      chk("rst_ir_clear", sximm8, 16'h0000);
      rst_n = 1'b1;
      tick(); chk_flags("rst_after", F_IDLE);
      tick(); chk_flags("rst_idle", F_IDLE);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
